conv_frame_sequencer: RTL and testbench

Frame-level control for the convolver datapath. Accepts a start pulse, then paces exactly IMAGE_SIZE×IMAGE_SIZE pixels from the upstream pixel stream through a ready/valid handshake. Drives the convolver's shift enable, tracks row/column position, and flags which shifts complete a valid KERNEL_SIZE×KERNEL_SIZE window. It then drains the datapath pipeline and pulses done. It sits between the pixel source and the convolver datapath, replacing free-running enable generation with a start/busy/done contract.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_frame_sequencer_valid_delay_line.sv | 28 ++
 rtl/conv_frame_sequencer.sv | 128 ++++++++++++
 tb/tb_conv_frame_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolver frame sequencer.
package conv_pkg;

  localparam int DEF_KERNEL_SIZE = 5;
  localparam int DEF_IMAGE_SIZE  = 28;
  localparam int DEF_PIPE_DEPTH  = 2;
  localparam int DEF_DATA_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // True when a pixel at (row, col) completes a full kernel window.
  function automatic logic in_window(input int row, input int col, input int kernel_size);
    return (row >= kernel_size - 1) && (col >= kernel_size - 1);
  endfunction

endpackage

// File: rtl/conv_frame_sequencer_valid_delay_line.sv
// Fixed-latency 1-bit delay matching the convolver pipeline; turns window
// hits into out_valid strobes aligned with the datapath result.
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage_r;

  // Shift the hit flag one stage per cycle; reset flushes pending pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_r <= {DEPTH{1'b0}};
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer: paces IMAGE_SIZE x IMAGE_SIZE pixels into the convolver,
// tracks position, flags complete windows, drains the pipeline, pulses done.
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE,
  parameter int PIPE_DEPTH  = DEF_PIPE_DEPTH,
  parameter int CNT_W       = $clog2(IMAGE_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             shift_en,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int               DRAIN_W    = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_DEPTH - 1);

  seq_state_e         state_r, state_s;
  logic [CNT_W-1:0]   row_r, row_s;
  logic [CNT_W-1:0]   col_r, col_s;
  logic [DRAIN_W-1:0] drain_cnt_r, drain_cnt_s;
  logic               pix_ready_r;
  logic               busy_r;
  logic               done_r;
  logic               shift_en_s;
  logic               win_hit_s;

  // pix_ready is a flop, so the accept strobe never loops back through pix_valid.
  assign shift_en_s = pix_valid & pix_ready_r;
  assign win_hit_s  = shift_en_s & in_window(int'(row_r), int'(col_r), KERNEL_SIZE);

  // Next-state, raster position and drain count.
  always_comb begin
    state_s     = state_r;
    row_s       = row_r;
    col_s       = col_r;
    drain_cnt_s = drain_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (shift_en_s) begin
          if (col_r == LAST_IDX) begin
            col_s = {CNT_W{1'b0}};
            if (row_r == LAST_IDX) begin
              row_s       = {CNT_W{1'b0}};
              drain_cnt_s = {DRAIN_W{1'b0}};
              state_s     = ST_DRAIN;
            end else begin
              row_s = row_r + CNT_W'(1);
            end
          end else begin
            col_s = col_r + CNT_W'(1);
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          drain_cnt_s = {DRAIN_W{1'b0}};
          state_s     = ST_DONE;
        end else begin
          drain_cnt_s = drain_cnt_r + DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs (decoded from next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      row_r       <= {CNT_W{1'b0}};
      col_r       <= {CNT_W{1'b0}};
      drain_cnt_r <= {DRAIN_W{1'b0}};
      pix_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      row_r       <= row_s;
      col_r       <= col_s;
      drain_cnt_r <= drain_cnt_s;
      pix_ready_r <= (state_s == ST_RUN);
      busy_r      <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      done_r      <= (state_s == ST_DONE);
    end
  end

  valid_delay_line #(
    .DEPTH (PIPE_DEPTH)
  ) u_valid_delay (
    .clk   (clk),
    .reset (reset),
    .din   (win_hit_s),
    .dout  (out_valid)
  );

  assign pix_ready = pix_ready_r;
  assign shift_en  = shift_en_s;
  assign row       = row_r;
  assign col       = col_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer: default instance plus a 4x4/K4/D1 corner
// instance, both tracked cycle by cycle against a timing-rule reference model.
module tb_conv_frame_sequencer;

  localparam int IMG0 = 28, K0 = 5, D0 = 2;
  localparam int IMG1 = 4,  K1 = 4, D1 = 1;
  localparam int HMAX = 16384;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] start_i = 2'b00;
  logic [1:0] pv_i = 2'b00;
  logic [1:0] ready_o, shift_o, ov_o, busy_o, done_o;
  logic [4:0] row0, col0;
  logic [1:0] row1, col1;

  always #5 clk = ~clk;

  conv_frame_sequencer #(.KERNEL_SIZE(K0), .IMAGE_SIZE(IMG0), .PIPE_DEPTH(D0)) dut0 (
    .clk(clk), .reset(reset), .start(start_i[0]), .pix_valid(pv_i[0]),
    .pix_ready(ready_o[0]), .shift_en(shift_o[0]), .row(row0), .col(col0),
    .out_valid(ov_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  conv_frame_sequencer #(.KERNEL_SIZE(K1), .IMAGE_SIZE(IMG1), .PIPE_DEPTH(D1)) dut1 (
    .clk(clk), .reset(reset), .start(start_i[1]), .pix_valid(pv_i[1]),
    .pix_ready(ready_o[1]), .shift_en(shift_o[1]), .row(row1), .col(col1),
    .out_valid(ov_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  int vectors = 0, miscompares = 0;
  int cyc = 0, last_id = 0;
  bit chk_en = 1'b0;

  // Reference model: frame described by accept count and event cycles only.
  int img[2] = '{IMG0, IMG1};
  int kk[2]  = '{K0, K1};
  int dd[2]  = '{D0, D1};
  int run_from[2] = '{-1, -1};
  int last_acc[2] = '{-1, -1};
  int acc_cnt[2]  = '{0, 0};
  bit ov_sched [0:1][0:HMAX-1];

  // Observations of the DUT, cleared per scenario.
  int n_shift[2], n_ov[2], n_done[2], n_busy[2];
  int first_shift[2], last_shift[2], first_ov[2], done_cyc[2];
  int acc_at[0:1023];
  bit ov_seen[0:HMAX-1];

  int m_npix, m_k;
  bit m_run, m_drain, m_done, m_idle, m_ov;
  logic [4:0] m_exp, m_obs, m_row_o, m_col_o, m_row_e, m_col_e;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_npix  = img[d] * img[d];
      m_run   = (run_from[d] >= 0) && (cyc >= run_from[d]) && (acc_cnt[d] < m_npix);
      m_drain = (last_acc[d] >= 0) && (cyc > last_acc[d]) && (cyc <= last_acc[d] + dd[d]);
      m_done  = (last_acc[d] >= 0) && (cyc == last_acc[d] + dd[d] + 1);
      m_idle  = !m_run && !m_drain && !m_done;
      m_ov    = ov_sched[d][cyc % HMAX];
      m_exp   = {m_run, m_run & pv_i[d], m_run | m_drain, m_done, m_ov};
      m_obs   = {ready_o[d], shift_o[d], busy_o[d], done_o[d], ov_o[d]};
      m_row_o = (d == 0) ? row0 : {3'b000, row1};
      m_col_o = (d == 0) ? col0 : {3'b000, col1};
      m_row_e = 5'((acc_cnt[d] % m_npix) / img[d]);
      m_col_e = 5'((acc_cnt[d] % m_npix) % img[d]);
      if (chk_en) begin
        vectors++;
        if (m_obs !== m_exp) begin
          miscompares++;
          $display("FAIL ctrl dut%0d cyc=%0d got=%b exp=%b (ready,shift,busy,done,out_valid)",
                   d, cyc, m_obs, m_exp);
        end
        vectors++;
        if (m_row_o !== m_row_e || m_col_o !== m_col_e) begin
          miscompares++;
          $display("FAIL rowcol dut%0d cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                   d, cyc, m_row_o, m_col_o, m_row_e, m_col_e);
        end
        if (shift_o[d] === 1'b1) begin
          if (n_shift[d] == 0) first_shift[d] = cyc;
          if (d == 0 && n_shift[0] < 1024) acc_at[n_shift[0]] = cyc;
          n_shift[d]++;
          last_shift[d] = cyc;
        end
        if (ov_o[d] === 1'b1) begin
          if (first_ov[d] < 0) first_ov[d] = cyc;
          n_ov[d]++;
        end
        if (d == 0) ov_seen[cyc % HMAX] = (ov_o[0] === 1'b1);
        if (busy_o[d] === 1'b1) n_busy[d]++;
        if (done_o[d] === 1'b1) begin
          n_done[d]++;
          done_cyc[d] = cyc;
        end
      end
      ov_sched[d][cyc % HMAX] = 1'b0;
      if (m_run && pv_i[d] === 1'b1) begin
        m_k = acc_cnt[d];
        if (m_k / img[d] >= kk[d] - 1 && m_k % img[d] >= kk[d] - 1)
          ov_sched[d][(cyc + dd[d]) % HMAX] = 1'b1;
        acc_cnt[d]++;
        if (acc_cnt[d] == m_npix) last_acc[d] = cyc;
      end
      if (m_idle && start_i[d] === 1'b1) begin
        run_from[d] = cyc + 1;
        acc_cnt[d]  = 0;
        last_acc[d] = -1;
      end
      if (reset === 1'b1) begin
        run_from[d] = -1;
        last_acc[d] = -1;
        acc_cnt[d]  = 0;
        for (int j = 1; j <= dd[d]; j++) ov_sched[d][(cyc + j) % HMAX] = 1'b0;
      end
    end
    cyc++;
  end

  task automatic drive(input logic [1:0] s, input logic [1:0] v, input logic r);
    @(posedge clk);
    #1;
    start_i = s;
    pv_i    = v;
    reset   = r;
    last_id = cyc;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rec();
    for (int d = 0; d < 2; d++) begin
      n_shift[d] = 0; n_ov[d] = 0; n_done[d] = 0; n_busy[d] = 0;
      first_shift[d] = -1; last_shift[d] = -1; first_ov[d] = -1; done_cyc[d] = -1;
    end
  endtask

  task automatic test_reset();
    drive(2'b00, 2'b00, 1'b1);
    chk_en = 1'b1;
    drive(2'b00, 2'b00, 1'b1);
    drive(2'b00, 2'b11, 1'b0);
    vectors++;
    if ({ready_o, shift_o, busy_o, done_o, ov_o} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b exp=0", {ready_o, shift_o, busy_o, done_o, ov_o});
    end
    vectors++;
    if ({row0, col0, row1, col1} !== 14'b0) begin
      miscompares++;
      $display("FAIL reset_rowcol got=%b exp=0", {row0, col0, row1, col1});
    end
  endtask

  task automatic test_continuous();
    int t0;
    clear_rec();
    drive(2'b01, 2'b01, 1'b0);
    t0 = last_id;
    for (int i = 0; i < 900 && n_done[0] == 0; i++) drive(2'b00, 2'b01, 1'b0);
    repeat (3) drive(2'b00, 2'b00, 1'b0);
    vectors++;
    if (n_shift[0] != 784 || first_shift[0] - t0 != 1 || last_shift[0] - t0 != 784) begin
      miscompares++;
      $display("FAIL cont_shift got n=%0d first=%0d last=%0d exp n=784 first=1 last=784",
               n_shift[0], first_shift[0] - t0, last_shift[0] - t0);
    end
    vectors++;
    if (first_ov[0] - t0 != 119) begin
      miscompares++;
      $display("FAIL cont_first_ov got=%0d exp=119", first_ov[0] - t0);
    end
    vectors++;
    if (n_ov[0] != 576) begin
      miscompares++;
      $display("FAIL cont_ov_count got=%0d exp=576", n_ov[0]);
    end
    vectors++;
    if (n_done[0] != 1 || done_cyc[0] - t0 != 787) begin
      miscompares++;
      $display("FAIL cont_done got n=%0d at=%0d exp n=1 at=787", n_done[0], done_cyc[0] - t0);
    end
    vectors++;
    if (n_busy[0] != 786) begin
      miscompares++;
      $display("FAIL cont_busy got=%0d exp=786", n_busy[0]);
    end
  endtask

  task automatic test_stalls();
    clear_rec();
    drive(2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 2000 && n_done[0] == 0; i++)
      drive(2'b00, (i % 2 == 0) ? 2'b01 : 2'b00, 1'b0);
    repeat (2) drive(2'b00, 2'b00, 1'b0);
    vectors++;
    if (n_shift[0] != 784 || n_ov[0] != 576) begin
      miscompares++;
      $display("FAIL stall_counts got shift=%0d ov=%0d exp 784/576", n_shift[0], n_ov[0]);
    end
    vectors++;
    if (n_done[0] != 1 || done_cyc[0] - last_shift[0] != D0 + 1) begin
      miscompares++;
      $display("FAIL stall_done got n=%0d gap=%0d exp n=1 gap=%0d",
               n_done[0], done_cyc[0] - last_shift[0], D0 + 1);
    end
  endtask

  task automatic test_row_wrap();
    clear_rec();
    drive(2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 500 && n_shift[0] < 28; i++)
      drive(2'b00, {1'b0, 1'($urandom_range(0, 1))}, 1'b0);
    drive(2'b00, 2'b00, 1'b0);
    vectors++;
    if (row0 !== 5'd1 || col0 !== 5'd0) begin
      miscompares++;
      $display("FAIL wrap_pos got=(%0d,%0d) exp=(1,0)", row0, col0);
    end
    for (int i = 0; i < 4000 && n_done[0] == 0; i++)
      drive(2'b00, {1'b0, 1'($urandom_range(0, 1))}, 1'b0);
    vectors++;
    if (ov_seen[(acc_at[115] + D0) % HMAX] !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_4_3 got out_valid=1 exp=0");
    end
    vectors++;
    if (ov_seen[(acc_at[116] + D0) % HMAX] !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_4_4 got out_valid=0 exp=1");
    end
    vectors++;
    if (n_ov[0] != 576 || n_done[0] != 1) begin
      miscompares++;
      $display("FAIL wrap_totals got ov=%0d done=%0d exp 576/1", n_ov[0], n_done[0]);
    end
  endtask

  task automatic test_start_outside_idle();
    clear_rec();
    drive(2'b01, 2'b01, 1'b0);
    for (int i = 0; i < 3000 && n_shift[0] < 784; i++)
      drive(($urandom_range(0, 15) == 0) ? 2'b01 : 2'b00,
            ($urandom_range(0, 3) != 0) ? 2'b01 : 2'b00, 1'b0);
    drive(2'b01, 2'b01, 1'b0);
    drive(2'b00, 2'b00, 1'b0);
    drive(2'b01, 2'b01, 1'b0);
    vectors++;
    if (done_o[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL done_cycle got done=%b exp=1", done_o[0]);
    end
    drive(2'b01, 2'b01, 1'b0);
    vectors++;
    if (ready_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || n_done[0] != 1) begin
      miscompares++;
      $display("FAIL idle_after_done got ready=%b busy=%b frames=%0d exp 0/0/1",
               ready_o[0], busy_o[0], n_done[0]);
    end
    drive(2'b00, 2'b01, 1'b0);
    vectors++;
    if (ready_o[0] !== 1'b1 || shift_o[0] !== 1'b1 || row0 !== 5'd0 || col0 !== 5'd0) begin
      miscompares++;
      $display("FAIL restart got ready=%b shift=%b pos=(%0d,%0d) exp 1/1/(0,0)",
               ready_o[0], shift_o[0], row0, col0);
    end
    for (int i = 0; i < 1000 && n_done[0] < 2; i++) drive(2'b00, 2'b01, 1'b0);
    vectors++;
    if (n_done[0] != 2 || n_shift[0] != 1568 || n_ov[0] != 1152) begin
      miscompares++;
      $display("FAIL two_frames got done=%0d shift=%0d ov=%0d exp 2/1568/1152",
               n_done[0], n_shift[0], n_ov[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int ov_snap, done_snap;
    clear_rec();
    drive(2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 3000 && n_shift[0] < 399; i++)
      drive(2'b00, {1'b0, 1'($urandom_range(0, 1))}, 1'b0);
    drive(2'b00, 2'b01, 1'b1);
    vectors++;
    if (n_shift[0] != 400) begin
      miscompares++;
      $display("FAIL abort_accepts got=%0d exp=400", n_shift[0]);
    end
    drive(2'b00, 2'b01, 1'b0);
    vectors++;
    if ({ready_o[0], shift_o[0], busy_o[0], done_o[0], ov_o[0], row0, col0} !== 15'b0) begin
      miscompares++;
      $display("FAIL abort_outputs got=%b exp=0",
               {ready_o[0], shift_o[0], busy_o[0], done_o[0], ov_o[0], row0, col0});
    end
    ov_snap = n_ov[0];
    done_snap = n_done[0];
    repeat (D0 + 1) drive(2'b00, 2'b01, 1'b0);
    vectors++;
    if (n_ov[0] != ov_snap || n_done[0] != done_snap || n_done[0] != 0) begin
      miscompares++;
      $display("FAIL abort_quiet got extra_ov=%0d done=%0d exp 0/0", n_ov[0] - ov_snap, n_done[0]);
    end
  endtask

  task automatic test_corner();
    clear_rec();
    drive(2'b10, 2'b10, 1'b0);
    for (int i = 0; i < 200 && n_done[1] == 0; i++)
      drive(2'b00, {1'($urandom_range(0, 1)), 1'b0}, 1'b0);
    repeat (2) drive(2'b00, 2'b00, 1'b0);
    vectors++;
    if (n_shift[1] != 16 || n_ov[1] != 1) begin
      miscompares++;
      $display("FAIL corner_counts got shift=%0d ov=%0d exp 16/1", n_shift[1], n_ov[1]);
    end
    vectors++;
    if (first_ov[1] - last_shift[1] != 1) begin
      miscompares++;
      $display("FAIL corner_ov_time got=%0d exp=1", first_ov[1] - last_shift[1]);
    end
    vectors++;
    if (n_done[1] != 1 || done_cyc[1] - last_shift[1] != 2) begin
      miscompares++;
      $display("FAIL corner_done got n=%0d gap=%0d exp 1/2", n_done[1], done_cyc[1] - last_shift[1]);
    end
  endtask

  initial begin
    clear_rec();
    test_reset();
    test_continuous();
    test_stalls();
    test_row_wrap();
    test_start_outside_idle();
    test_reset_mid_frame();
    test_corner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
